seq_pattern_tx: RTL and testbench

//  Serial pattern transmitter: the sending end of the 1011010 serial-detect link.
//  On a start request it shifts a fixed PAT_W-bit pattern out MSB-first, one bit per clk,

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_frame_ctr.sv | 46 ++++
 rtl/seq_pattern_tx.sv | 136 +++++++++++++
 tb/tb_seq_pattern_tx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// Holds the FSM state enum and the default 1011010 pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } tx_state_t;

  localparam int DEFAULT_PAT_W = 7;
  localparam logic [DEFAULT_PAT_W-1:0] DEFAULT_PATTERN = 7'b1011010;

endpackage

// File: rtl/seq_frame_ctr.sv
// Bit-index and frame-count down-counters for seq_pattern_tx.
// Ports: clk, rst (async low), load, dec, frames -> bit_idx, last_bit, last_frame.
module seq_frame_ctr #(
  parameter int PAT_W = 7,
  parameter int CNT_W = 8,
  parameter int IW    = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] frames,
  output logic [IW-1:0]    bit_idx,
  output logic             last_bit,
  output logic             last_frame
);

  localparam logic [IW-1:0] TOP = IW'(PAT_W - 1);

  logic [IW-1:0]    bit_q;
  logic [CNT_W-1:0] frm_q;

  // dec past bit 0 reloads the index and retires one frame;
  // the frame count stops at zero instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_q <= '0;
      frm_q <= '0;
    end else if (load) begin
      bit_q <= TOP;
      frm_q <= (frames == '0) ? CNT_W'(1) : frames;
    end else if (dec) begin
      if (bit_q == '0) begin
        bit_q <= TOP;
        if (frm_q != '0) frm_q <= frm_q - CNT_W'(1);
      end else begin
        bit_q <= bit_q - IW'(1);
      end
    end
  end

  assign bit_idx    = bit_q;
  assign last_bit   = (bit_q == '0);
  assign last_frame = (frm_q <= CNT_W'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first, repeated per frame count.
// Ports: clk, rst (async low), start, repeat_cnt, abort -> out, out_valid, busy, done.
// Build option SEQ_PATTERN_TX_PARITY_EN appends an even-parity bit to each frame.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W    = DEFAULT_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN  = DEFAULT_PATTERN,
  parameter int               CNT_W    = 8,
  parameter logic             IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(PAT_W);

  tx_state_t state_q, state_d;

  logic out_q, out_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic last_q, last_d;

  logic          load, dec;
  logic [IW-1:0] bit_idx;
  logic          last_bit, last_frame;

  seq_frame_ctr #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W),
    .IW    (IW)
  ) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .dec        (dec),
    .frames     (repeat_cnt),
    .bit_idx    (bit_idx),
    .last_bit   (last_bit),
    .last_frame (last_frame)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      out_q   <= IDLE_LVL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  // The state leads the output registers by one cycle, so the
  // FSM is back in IDLE while the final bit is still on out;
  // busy_q blocks a start in that cycle.
  always_comb begin
    state_d = state_q;
    out_d   = IDLE_LVL;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    last_d  = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    // last_q marks the final bit on out; abort then swallows done
    done_d  = last_q & ~abort;
    unique case (state_q)
      IDLE: begin
        if (start && !abort && !busy_q) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          out_d   = PATTERN[bit_idx];
          valid_d = 1'b1;
          busy_d  = 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
          if (last_bit) state_d = PARITY;
          else          dec     = 1'b1;
`else
          dec = 1'b1;
          if (last_bit && last_frame) begin
            state_d = IDLE;
            last_d  = 1'b1;
          end
`endif
        end
      end
`ifdef SEQ_PATTERN_TX_PARITY_EN
      PARITY: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          out_d   = ^PATTERN;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          dec     = 1'b1;
          if (last_frame) begin
            state_d = IDLE;
            last_d  = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: frame streams, repeats, abort, reset.
// Inputs change and outputs are checked on the falling clock edge.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] repeat_cnt = 8'd0;
  logic       abort = 1'b0;
  logic       out, out_valid, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] pat = 7'b1011010;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int FL = 8;
`else
  localparam int FL = 7;
`endif

  seq_pattern_tx dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .repeat_cnt (repeat_cnt),
    .abort      (abort),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out"}, out, 1'b0);
    chk({tag, ".valid"}, out_valid, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
  endtask

  function automatic logic exp_bit(input int i);
    int k;
    k = i % FL;
    if (k == 7) return ^pat;
    return pat[6-k];
  endfunction

  // Request a run at the current negedge and follow it bit by bit.
  // poke: bit at which start is re-pulsed and repeat_cnt changed.
  // ab/rs: bit at which abort / reset is applied (-1 = never).
  task automatic send(input logic [7:0] rc, input int nb,
                      input int poke, input int ab, input int rs);
    start = 1'b1;
    repeat_cnt = rc;
    @(negedge clk);
    start = 1'b0;
    chk_idle("lat");
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("bit%0d", i), out, exp_bit(i));
      chk("valid", out_valid, 1'b1);
      chk("busy", busy, 1'b1);
      chk("nodone", done, 1'b0);
      if (i == poke) begin
        start = 1'b1;
        repeat_cnt = 8'd5;
      end
      if (i == ab) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort");
        return;
      end
      if (i == rs) begin
        #2 rst = 1'b0;
        #1 chk_idle("rst_async");
        @(negedge clk);
        chk_idle("rst_hold");
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk_idle("rst_stay");
        end
        return;
      end
    end
    @(negedge clk);
    chk("done", done, 1'b1);
    chk("end.valid", out_valid, 1'b0);
    chk("end.busy", busy, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    // single frame, then back-to-back restarts in the done cycle
    send(8'd1, FL, -1, -1, -1);
    send(8'd3, 3 * FL, -1, -1, -1);
    send(8'd0, FL, -1, -1, -1);
    @(negedge clk);
    chk_idle("quiet");

    // start and repeat_cnt changes while busy are ignored
    send(8'd1, FL, 1, -1, -1);
    @(negedge clk);
    chk_idle("after_poke");

    // abort on the 4th bit, restart the next cycle
    send(8'd2, 2 * FL, -1, 3, -1);
    send(8'd1, FL, -1, -1, -1);
    @(negedge clk);

    // abort and start together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    repeat_cnt = 8'd1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk_idle("ab_start1");
    @(negedge clk);
    chk_idle("ab_start2");

    // reset on the 5th bit, then a clean frame
    send(8'd1, FL, -1, -1, 4);
    send(8'd1, FL, -1, -1, -1);
    @(negedge clk);

    // maximum repeat count
    send(8'd255, 255 * FL, -1, -1, -1);
    @(negedge clk);
    chk_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
